// File: rtl/register_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : register_dump_sequencer
// Function : Walks the decode-stage debug read port over every register while
//            the pipeline is halted and streams each word, LSB byte first,
//            over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module register_dump_sequencer #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_halted,
    output logic [NB_ADDR-1:0] o_r_addr,
    input  logic [NB_DATA-1:0] i_r_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_abort
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [NB_ADDR-1:0] c_LAST_IDX  = NB_ADDR'(N_REGS - 1);
    localparam logic [NB_CNT-1:0]  c_LAST_BYTE = NB_CNT'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_ADDR-1:0]  r_idx;
    logic [NB_ADDR-1:0]  w_idx_next;
    logic [NB_CNT-1:0]   r_byte_cnt;
    logic [NB_CNT-1:0]   w_byte_cnt_next;
    logic [NB_DATA-1:0]  r_shift;
    logic [NB_DATA-1:0]  w_shift_next;

    logic w_xfer;
    logic w_last_byte;
    logic w_last_reg;

    assign w_xfer      = (r_state == S_SEND) && i_tx_ready;
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_last_reg  = (r_idx == c_LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_shift    <= w_shift_next;
        end
    end

    // The read index is cleared on every path back to IDLE so the debug
    // address rests at zero whenever no dump is running.
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_byte_cnt_next = r_byte_cnt;
        w_shift_next    = r_shift;

        case (r_state)
            S_IDLE: begin
                if (i_start && i_halted) begin
                    w_idx_next   = '0;
                    w_state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                if (!i_halted) begin
                    w_idx_next   = '0;
                    w_state_next = S_ABORT;
                end else begin
                    w_shift_next    = i_r_data;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_SEND;
                end
            end

            // Halt is deliberately not sampled here: a started word always
            // drains completely so the receiver never sees a partial word.
            S_SEND: begin
                if (w_xfer) begin
                    w_shift_next = r_shift >> 8;
                    if (w_last_byte) begin
                        w_byte_cnt_next = '0;
                        if (w_last_reg) begin
                            w_idx_next   = '0;
                            w_state_next = S_DONE;
                        end else begin
                            w_idx_next   = r_idx + 1'b1;
                            w_state_next = S_LOAD;
                        end
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 1'b1;
                    end
                end
            end

            S_DONE:  w_state_next = S_IDLE;
            S_ABORT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_r_addr   = r_idx;
    assign o_tx_valid = (r_state == S_SEND);
    assign o_tx_data  = (r_state == S_SEND) ? r_shift[7:0] : 8'h00;
    assign o_busy     = (r_state == S_LOAD) || (r_state == S_SEND);
    assign o_done     = (r_state == S_DONE);
    assign o_abort    = (r_state == S_ABORT);

endmodule
`default_nettype wire

// File: tb/tb_register_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_dump_sequencer
// Function : Self-checking bench for register_dump_sequencer with a byte
//            stream reference model and random transmitter backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_dump_sequencer;

    localparam int NB_ADDR = 5;
    localparam int NB_DATA = 32;
    localparam int N_REGS  = 32;
    localparam int N_BYTES = N_REGS * NB_DATA / 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               halted;
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_DATA-1:0] r_data;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done;
    logic               abort_p;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got[$];
    int  cyc = 0;
    int  load_cyc = 0;
    int  done_cyc = 0;
    int  n_done = 0;
    int  n_abort = 0;
    logic busy_at_done = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_rst = 1'b1;
    logic prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic rnd_ready = 1'b0;

    register_dump_sequencer #(
        .NB_ADDR(NB_ADDR),
        .NB_DATA(NB_DATA),
        .N_REGS (N_REGS)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_halted  (halted),
        .o_r_addr  (r_addr),
        .i_r_data  (r_data),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_abort   (abort_p)
    );

    // Decode-stage register file stand-in
    assign r_data = 32'hA500_0000 + 32'(r_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] word;
        word = 32'hA500_0000 + 32'(i / 4);
        return 8'((word >> (8 * (i % 4))) & 32'hFF);
    endfunction

    // Values at the falling edge are those the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && !prev_rst) begin
            n_tests++;
            assert (tx_valid === 1'b1 && tx_data === prev_data) else begin
                n_fail++;
                $error("FAIL hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
                       tx_valid, tx_data, prev_data);
            end
        end
        if (tx_valid && tx_ready && !rst) got.push_back(tx_data);
        if (busy && !prev_busy) load_cyc = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (abort_p) n_abort++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_rst   = rst;
        prev_busy  = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) tx_ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic clear_obs();
        got.delete();
        n_done  = 0;
        n_abort = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int k;
        k = 0;
        while (n_done == 0 && n_abort == 0 && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_stream(input int n, input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_byte(i)));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"},  32'(r_addr),   32'd0);
        check({tag, "_data"},  32'(tx_data),  32'd0);
        check({tag, "_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_abort"}, 32'(abort_p),  32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; halted = 1'b0; tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_idle("reset");

        // Start without halt must be ignored
        clear_obs();
        start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        check("nohalt_busy", 32'(busy), 32'd0);
        check("nohalt_bytes", 32'(got.size()), 32'd0);
        check("nohalt_done", 32'(n_done), 32'd0);

        // Full dump, ready high, with a stray start while busy
        clear_obs();
        halted = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        pulse_start();
        repeat (40) tick();
        pulse_start();
        wait_end(400, "full");
        tick();
        check_stream(N_BYTES, "full");
        check("full_done_cnt", 32'(n_done), 32'd1);
        check("full_abort_cnt", 32'(n_abort), 32'd0);
        check("full_done_cycle", 32'(done_cyc - load_cyc + 1), 32'd161);
        check("full_busy_at_done", 32'(busy_at_done), 32'd0);
        tick();
        check_idle("after_full");

        // Random 30% backpressure
        clear_obs();
        rnd_ready = 1'b1;
        pulse_start();
        wait_end(4000, "bp");
        repeat (2) tick();
        check_stream(N_BYTES, "bp");
        check("bp_done_cnt", 32'(n_done), 32'd1);
        check("bp_busy", 32'(busy), 32'd0);

        // Abort: halt drops while the second byte of register 3 is offered
        clear_obs();
        pulse_start();
        k = 0;
        while (!(got.size() == 13 && tx_valid) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) check("abort_sync_timeout", 32'd0, 32'd1);
        check("abort_addr_at_drop", 32'(r_addr), 32'd3);
        halted = 1'b0;
        wait_end(1000, "abort");
        repeat (2) tick();
        check_stream(16, "abort");
        check("abort_cnt", 32'(n_abort), 32'd1);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_valid", 32'(tx_valid), 32'd0);
        halted = 1'b1;

        // Reset mid-byte, then a clean restart from register 0
        clear_obs();
        pulse_start();
        k = 0;
        while (!(got.size() >= 6 && tx_valid) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) check("midrst_sync_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        tick();
        check_idle("midrst");
        rst = 1'b0;
        rnd_ready = 1'b0;
        tx_ready = 1'b1;
        tick();
        clear_obs();
        pulse_start();
        wait_end(400, "restart");
        tick();
        check_stream(N_BYTES, "restart");
        check("restart_done_cnt", 32'(n_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
